// File: rtl/serial_frame_rx.sv
// Serial frame receiver: two-flop synchronizer, start-bit qualification, LSB-first
// data capture and stop-bit check, with one-cycle valid / frame_err pulses.
module serial_frame_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t            state, state_nx;
    logic              sync1, sync2;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [BW-1:0]     bidx, bidx_nx;
    logic [DATA_W-1:0] sh, sh_nx;
    logic [DATA_W-1:0] data_nx;
    logic              valid_nx, ferr_nx;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bidx      <= '0;
            sh        <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            bidx      <= bidx_nx;
            sh        <= sh_nx;
            data_out  <= data_nx;
            valid     <= valid_nx;
            frame_err <= ferr_nx;
            busy      <= (state_nx != IDLE);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (!sync2) state_nx = START;
            START:     if (cnt == HALF_END) state_nx = sync2 ? IDLE : DATA;
            DATA:      if (cnt == BIT_END && bidx == LAST_BIT) state_nx = STOP;
            STOP:      if (cnt == BIT_END) state_nx = sync2 ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (sync2) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        cnt_nx   = '0;
        bidx_nx  = bidx;
        sh_nx    = sh;
        data_nx  = data_out;
        valid_nx = 1'b0;
        ferr_nx  = 1'b0;
        case (state)
            START: begin
                cnt_nx = (cnt == HALF_END) ? '0 : cnt + 1'b1;
                if (cnt == HALF_END) bidx_nx = '0;
            end
            DATA: begin
                cnt_nx = (cnt == BIT_END) ? '0 : cnt + 1'b1;
                if (cnt == BIT_END) begin
                    // Shift form stays legal for DATA_W == 1.
                    sh_nx   = (sh >> 1) | (DATA_W'(sync2) << (DATA_W - 1));
                    bidx_nx = bidx + 1'b1;
                end
            end
            STOP: begin
                cnt_nx = (cnt == BIT_END) ? '0 : cnt + 1'b1;
                if (cnt == BIT_END) begin
                    if (sync2) begin
                        data_nx  = sh;
                        valid_nx = 1'b1;
                    end else begin
                        ferr_nx = 1'b1;
                    end
                end
            end
            default: cnt_nx = '0;
        endcase
    end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Serial frame receiver sitting downstream of the edge-triggered flop stage. It takes an asynchronous, idle-high serial line and re-times it through a two-flop synchronizer. It detects and qualifies a start bit, then shifts in DATA_W bits LSB-first at a fixed bit period, checks the stop bit, and presents the word with a one-cycle valid pulse or a one-cycle framing-error pulse.

## Interface
- DATA_W, 8, data bits per frame (1..16)
- CLKS_PER_BIT, 16, clk cycles per bit; must be even and ≥4
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- din  input  1  asynchronous serial line, idle high
- data_out  output  DATA_W  last correctly framed word
- valid  output  1  one-cycle pulse, data_out updated this cycle
- frame_err  output  1  one-cycle pulse, stop bit sampled low
- busy  output  1  high whenever FSM not in IDLE

## Operation
- din passes through 2 flops (sync1, sync2); sync2 is the only din value the FSM uses. Both flops reset to 1.
- Counter cnt of width clog2(CLKS_PER_BIT), bit index bidx of width clog2(DATA_W+1), shift register sh[DATA_W-1:0].
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: sync2==0 → START, cnt=0.
- START: cnt increments each cycle. At cnt==CLKS_PER_BIT/2-1:
  - sync2==0 → DATA, cnt=0, bidx=0.
  - sync2==1 → IDLE. This is a glitch: no pulse, no error.
- DATA: cnt increments each cycle. At cnt==CLKS_PER_BIT-1: sh = {sync2, sh[DATA_W-1:1]} (LSB-first), cnt=0, bidx+1. After the DATA_W-th sample → STOP.
- STOP: at cnt==CLKS_PER_BIT-1, sample sync2:
  - 1 → data_out=sh, valid=1 next cycle, → IDLE.
  - 0 → frame_err=1 next cycle, data_out unchanged, → WAIT_HIGH.
- WAIT_HIGH: stay until sync2==1, then → IDLE. A held-low line (break) never starts a new frame.
- valid and frame_err are registered and never high together. Each lasts exactly one cycle.
- busy = (state != IDLE), registered with state.

## Timing
- Reset (rst low, asynchronous): state=IDLE, sync1=sync2=1, cnt=0, bidx=0, sh=0, data_out=0, valid=0, frame_err=0, busy=0.
- Reset asserted mid-frame aborts the frame immediately. No valid and no frame_err are emitted for that frame. The first frame after release requires a fresh falling edge.
- Detect latency: din falling before edge E0 → sync2 low after E1 → FSM enters START at E2 (Es = E2, busy high after Es).
- Start qualify at edge Es+CLKS_PER_BIT/2.
- Data bit k is sampled at edge Es+CLKS_PER_BIT/2+(k+1)*CLKS_PER_BIT.
- valid/frame_err are high in the cycle after edge Es+CLKS_PER_BIT/2+(DATA_W+1)*CLKS_PER_BIT. With defaults this is Es+152.
- FSM returns to IDLE at the stop-sample edge, in mid stop bit. A following start edge, arriving half a bit later, is accepted, so back-to-back frames with zero idle are supported.
- Glitch shorter than CLKS_PER_BIT/2 cycles (as seen at sync2): busy high for CLKS_PER_BIT/2 cycles, then low. No outputs change.

## Test plan
- Reset, then send 0xA5 (start 0, bits LSB-first, stop 1) at 16 clk/bit → valid high for exactly 1 cycle at Es+152, data_out=0xA5, frame_err=0, busy low after.
- 0x00 then 0xFF back-to-back with no idle gap → two valid pulses exactly 160 cycles apart, data_out 0x00 then 0xFF, no frame_err.
- din low for 4 cycles, then high → busy high 8 cycles then low, valid=0, frame_err=0, data_out unchanged.
- Send 0x3C with stop bit 0, then hold din low 40 more cycles → frame_err single pulse, data_out keeps prior value, busy stays high until 2 cycles after din rises. A following 0x11 frame is received correctly.
- Assert rst during data bit 4 of 0x77 → all outputs reset immediately, without a clock edge. After release, 0x5A is received with valid and data_out=0x5A, and no pulse is ever seen for 0x77.
- DATA_W=5, CLKS_PER_BIT=4, send 0x15 → valid at Es+26, data_out=5'h15.
